// File: rtl/rd_addr_gen_if.sv
// rtl/rd_addr_gen_if.sv - start/config inputs, MIG read-command handshake and status of rd_addr_gen
interface rd_addr_gen_if #(
  parameter int ADDR_W = 28
);
  logic [3:0]        DIMMdepth_ctrl;
  logic [ADDR_W-2:0] addr_trig;
  logic [ADDR_W-4:0] pre_bursts;
  logic              rd_start;
  logic              data_fifo_afull;
  logic              rd_cmd_rdy;
  logic              rd_cmd_valid;
  logic [ADDR_W-1:0] addr_rd_out;
  logic              rd_busy;
  logic              rd_done;
  logic [3:0]        rd_state_out;

  // master: the address generator issuing read commands
  modport master (
    input  DIMMdepth_ctrl, addr_trig, pre_bursts, rd_start,
    input  data_fifo_afull, rd_cmd_rdy,
    output rd_cmd_valid, addr_rd_out, rd_busy, rd_done, rd_state_out
  );

  // slave: control logic plus the MIG command port it talks to
  modport slave (
    output DIMMdepth_ctrl, addr_trig, pre_bursts, rd_start,
    output data_fifo_afull, rd_cmd_rdy,
    input  rd_cmd_valid, addr_rd_out, rd_busy, rd_done, rd_state_out
  );
endinterface

// File: rtl/rd_addr_gen.sv
// rtl/rd_addr_gen.sv - replays the circular DDR acquisition buffer as one read command per 512-bit burst
module rd_addr_gen #(
  parameter int ADDR_W = 28,
  parameter int CNT_W  = 26
) (
  input  logic          clk,
  input  logic          rst,
  rd_addr_gen_if.master bus
);

  localparam int BW = ADDR_W - 3;

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_LOAD  = 4'b0010;
  localparam logic [3:0] S_ISSUE = 4'b0100;
  localparam logic [3:0] S_DONE  = 4'b1000;

  localparam logic [BW-1:0]    IDX_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [3:0]       state_lag;

  logic [3:0]       depth_q;
  logic [BW-1:0]    trig_burst_q;
  logic [BW-1:0]    pre_q;

  logic [BW-1:0]    mask_q;
  logic [CNT_W-1:0] n_bursts_q;
  logic [BW-1:0]    burst_idx;
  logic [CNT_W-1:0] issued;
  logic             cmd_valid;

  logic [4:0]       b_load;
  logic [BW-1:0]    mask_load;
  logic [CNT_W-1:0] n_load;
  logic [BW-1:0]    start_load;
  logic             accept;
  logic             last_cmd;
  logic             busy_c;
  logic             done_c;

  // Burst-index width (depth window W minus the 3 byte-in-burst bits) per depth code
  function automatic logic [4:0] burst_bits(input logic [3:0] d);
    logic [4:0] b;
    case (d)
      4'b1111: b = 5'd25;
      4'b1110: b = 5'd24;
      4'b1101: b = 5'd23;
      4'b1100: b = 5'd22;
      4'b1011: b = 5'd21;
      4'b1010: b = 5'd20;
      4'b1001: b = 5'd19;
      4'b1000: b = 5'd18;
      4'b0111: b = 5'd17;
      4'b0110: b = 5'd16;
      4'b0101: b = 5'd14;
      4'b0100: b = 5'd13;
      4'b0011: b = 5'd11;
      4'b0010: b = 5'd9;
      4'b0001: b = 5'd7;
      4'b0000: b = 5'd5;
      default: b = 5'd17;
    endcase
    return b;
  endfunction

  always_comb begin
    b_load     = burst_bits(depth_q);
    mask_load  = ~({BW{1'b1}} << b_load);
    n_load     = CNT_ONE << b_load;
    // Oldest wanted burst; pre-trigger lengths beyond the window wrap silently
    start_load = (trig_burst_q - pre_q) & mask_load;
  end

  assign accept   = cmd_valid & bus.rd_cmd_rdy;
  assign last_cmd = ((issued + CNT_ONE) == n_bursts_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      state_lag <= S_IDLE;
    end else begin
      state     <= state_nxt;
      state_lag <= state;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.rd_start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: if (accept && last_cmd) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      S_LOAD:  busy_c = 1'b1;
      S_ISSUE: busy_c = 1'b1;
      S_DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
        done_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      depth_q      <= '0;
      trig_burst_q <= '0;
      pre_q        <= '0;
      mask_q       <= '0;
      n_bursts_q   <= '0;
      burst_idx    <= '0;
      issued       <= '0;
      cmd_valid    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_valid <= 1'b0;
          if (bus.rd_start) begin
            depth_q      <= bus.DIMMdepth_ctrl;
            trig_burst_q <= bus.addr_trig[ADDR_W-2:2];
            pre_q        <= bus.pre_bursts;
          end
        end
        S_LOAD: begin
          mask_q     <= mask_load;
          n_bursts_q <= n_load;
          burst_idx  <= start_load;
          issued     <= '0;
          cmd_valid  <= 1'b0;
        end
        S_ISSUE: begin
          // A raised command is held until taken; afull only gates raising it
          if (accept) begin
            burst_idx <= (burst_idx + IDX_ONE) & mask_q;
            issued    <= issued + CNT_ONE;
            cmd_valid <= !last_cmd && !bus.data_fifo_afull;
          end else if (!cmd_valid && !bus.data_fifo_afull) begin
            cmd_valid <= 1'b1;
          end
        end
        default: cmd_valid <= 1'b0;
      endcase
    end
  end

  assign bus.rd_cmd_valid = cmd_valid;
  assign bus.addr_rd_out  = {burst_idx, 3'b000};
  assign bus.rd_busy      = busy_c;
  assign bus.rd_done      = done_c;
  assign bus.rd_state_out = state_lag;

endmodule

// File: tb/tb_rd_addr_gen.sv
// tb/tb_rd_addr_gen.sv - scoreboard bench for rd_addr_gen read-address replay
module tb_rd_addr_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  rd_addr_gen_if #(.ADDR_W(28)) bus ();

  rd_addr_gen #(.ADDR_W(28), .CNT_W(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];
  logic        mon_en;
  int          acc_cnt;
  int          pushed_cnt;
  int          done_cnt;
  int          done_cyc;
  int          last_acc_cyc;
  int          seq_n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Depth window W straight from the depth-code table
  function automatic int window_w(input logic [3:0] d);
    case (d)
      4'hF: return 28; 4'hE: return 27; 4'hD: return 26; 4'hC: return 25;
      4'hB: return 24; 4'hA: return 23; 4'h9: return 22; 4'h8: return 21;
      4'h7: return 20; 4'h6: return 19; 4'h5: return 17; 4'h4: return 16;
      4'h3: return 14; 4'h2: return 12; 4'h1: return 10; default: return 8;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd_cmd_valid && bus.rd_cmd_rdy) begin
        got_q.push_back(bus.addr_rd_out);
        acc_cnt++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) check("spurious_cmd", acc_cnt, pushed_cnt);
        else check("addr", bus.addr_rd_out, exp_q.pop_front());
      end
      if (bus.rd_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_seq(input logic [3:0] d, input logic [26:0] t, input logic [24:0] p,
                           input int lim);
    longint nb;
    longint msk;
    longint s;
    nb  = 64'd1 << (window_w(d) - 3);
    msk = nb - 1;
    s   = (longint'(t >> 2) - longint'(p)) & msk;
    seq_n = int'(nb);
    exp_q.delete();
    got_q.delete();
    acc_cnt    = 0;
    pushed_cnt = 0;
    for (longint i = 0; i < nb && i < lim; i++) begin
      exp_q.push_back(28'(((s + i) & msk) << 3));
      pushed_cnt++;
    end
    bus.DIMMdepth_ctrl = d;
    bus.addr_trig      = t;
    bus.pre_bursts     = p;
    bus.rd_start       = 1'b1;
    tick();
    bus.rd_start       = 1'b0;
    // Inputs after the start edge must not matter
    bus.DIMMdepth_ctrl = ~d;
    bus.addr_trig      = 27'($urandom);
    bus.pre_bursts     = 25'($urandom);
  endtask

  task automatic wait_done(input bit bp, input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      if (bp) begin
        bus.rd_cmd_rdy      = 1'($urandom_range(0, 1));
        bus.data_fifo_afull = ($urandom_range(0, 3) == 0);
      end
      tick();
      n++;
    end
    bus.rd_cmd_rdy      = 1'b1;
    bus.data_fifo_afull = 1'b0;
    check("done_seen", done_cnt != d0, 1);
    check("cmd_count", acc_cnt, seq_n);
    check("queue_left", exp_q.size(), 0);
    check("done_lat", done_cyc - last_acc_cyc, 1);
    check("done_pulse", bus.rd_done, 0);
    check("busy_after", bus.rd_busy, 0);
    check("state_lag_done", bus.rd_state_out, 4'b1000);
  endtask

  task automatic wait_acc(input int n_acc, input int budget);
    int n;
    n = 0;
    while (acc_cnt < n_acc && n < budget) begin
      tick();
      n++;
    end
    check("acc_reached", acc_cnt >= n_acc, 1);
  endtask

  initial begin
    logic [27:0] a0;
    bit          stable;
    int          d0;
    checks = 0; errors = 0; cyc = 0;
    mon_en = 1'b0; acc_cnt = 0; pushed_cnt = 0; done_cnt = 0;
    done_cyc = 0; last_acc_cyc = 0; seq_n = 0;
    rst = 1'b0;
    bus.DIMMdepth_ctrl  = 4'h0;
    bus.addr_trig       = '0;
    bus.pre_bursts      = '0;
    bus.rd_start        = 1'b0;
    bus.data_fifo_afull = 1'b0;
    bus.rd_cmd_rdy      = 1'b1;
    repeat (3) tick();
    check("rst_valid", bus.rd_cmd_valid, 0);
    check("rst_addr", bus.addr_rd_out, 0);
    check("rst_busy", bus.rd_busy, 0);
    check("rst_done", bus.rd_done, 0);
    check("rst_state", bus.rd_state_out, 4'b0001);
    rst = 1'b1;
    tick();
    mon_en = 1'b1;

    // Depth 0000, trigger burst 16, 8 pre-bursts: start at 0x40, full rdy
    start_seq(4'h0, 27'h40, 25'd8, 64);
    check("busy_load", bus.rd_busy, 1);
    check("valid_load", bus.rd_cmd_valid, 0);
    tick();
    check("valid_k1", bus.rd_cmd_valid, 0);
    check("state_lag_load", bus.rd_state_out, 4'b0010);
    tick();
    check("valid_k2", bus.rd_cmd_valid, 1);
    check("first_addr_k2", bus.addr_rd_out, 28'h40);
    wait_done(1'b0, 200);
    check("s1_first", got_q[0], 28'h40);
    check("s1_top", got_q[23], 28'hF8);
    check("s1_wrap", got_q[24], 28'h00);
    check("s1_last", got_q[31], 28'h38);

    // Start burst 29 with a restart attempt mid-ISSUE
    tick();
    start_seq(4'h0, 27'h08, 25'd5, 64);
    repeat (6) tick();
    bus.DIMMdepth_ctrl = 4'hF;
    bus.addr_trig      = 27'h123;
    bus.pre_bursts     = 25'd3;
    bus.rd_start       = 1'b1;
    tick();
    bus.rd_start       = 1'b0;
    wait_done(1'b0, 200);
    check("s2_first", got_q[0], 28'hE8);
    check("s2_top", got_q[2], 28'hF8);
    check("s2_wrap", got_q[3], 28'h00);
    d0 = acc_cnt;
    repeat (5) tick();
    check("no_restart_busy", bus.rd_busy, 0);
    check("no_restart_cmds", acc_cnt, d0);

    // pre_bursts beyond the window wraps (40 mod 32 = 8)
    start_seq(4'h0, 27'h40, 25'd40, 64);
    wait_done(1'b0, 200);
    check("s40_first", got_q[0], 28'h40);
    check("s40_last", got_q[31], 28'h38);

    // Backpressure: afull before issue, then rdy held low with afull toggling
    bus.rd_cmd_rdy      = 1'b0;
    bus.data_fifo_afull = 1'b1;
    start_seq(4'h0, 27'h40, 25'd8, 64);
    repeat (6) tick();
    check("afull_hold", bus.rd_cmd_valid, 0);
    bus.data_fifo_afull = 1'b0;
    tick();
    tick();
    check("valid_after_afull", bus.rd_cmd_valid, 1);
    a0 = bus.addr_rd_out;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_fifo_afull = ~bus.data_fifo_afull;
      tick();
      if (bus.rd_cmd_valid !== 1'b1 || bus.addr_rd_out !== a0) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_addr", a0, 28'h40);
    wait_done(1'b1, 3000);

    // Reset mid-ISSUE abandons the sequence, then a fresh run completes
    start_seq(4'h0, 27'h40, 25'd8, 64);
    wait_acc(10, 100);
    mon_en = 1'b0;
    rst    = 1'b0;
    d0     = done_cnt;
    tick();
    check("mid_rst_valid", bus.rd_cmd_valid, 0);
    check("mid_rst_state", bus.rd_state_out, 4'b0001);
    check("mid_rst_busy", bus.rd_busy, 0);
    check("mid_rst_addr", bus.addr_rd_out, 0);
    rst = 1'b1;
    exp_q.delete();
    acc_cnt = 0;
    pushed_cnt = 0;
    mon_en = 1'b1;
    repeat (5) tick();
    check("mid_rst_no_done", done_cnt, d0);
    check("mid_rst_no_cmd", acc_cnt, 0);
    start_seq(4'h0, 27'h40, 25'd8, 64);
    wait_done(1'b0, 200);
    check("post_rst_first", got_q[0], 28'h40);

    // Full depth: top burst then wrap to 0, aborted by reset
    start_seq(4'hF, 27'h7FFFFFC, 25'd0, 8);
    wait_acc(2, 100);
    mon_en = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("w_cnt", got_q.size() >= 2, 1);
    check("w_first", got_q[0], 28'hFFFFFF8);
    check("w_second", got_q[1], 28'h0000000);
    exp_q.delete();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_addr_gen.md
Name: rd_addr_gen

Overview:
- Read-side counterpart of the DDR acquisition write address generator.
- After an acquisition stops, it replays the captured circular buffer from DDR in time order. It starts at the oldest wanted burst, which is the trigger burst minus the pre-trigger length, wrapped within the active depth window.
- It issues one read-command address per 512-bit burst (8 x 64-bit) to the MIG read path. It honours command and data-FIFO backpressure and signals completion to the readout/upload logic.

Parameters:
- ADDR_W, 28, DDR address width (byte-burst address, low 3 bits always 0).
- CNT_W, 26, burst counter width; must hold 2^25 (maximum burst count).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- DIMMdepth_ctrl  in  4  depth select, same encoding as the write side; sampled at rd_start
- addr_trig  in  27  trigger position in 128-bit ADC-word units; sampled at rd_start
- pre_bursts  in  25  pre-trigger length in 512-bit bursts; sampled at rd_start
- rd_start  in  1  single-cycle start request; honoured only in IDLE
- data_fifo_afull  in  1  downstream read-data FIFO almost full
- rd_cmd_rdy  in  1  MIG accepts the command this cycle
- rd_cmd_valid  out  1  command valid
- addr_rd_out  out  28  read address = {burst_idx masked, 3'b000}
- rd_busy  out  1  high from LOAD through DONE
- rd_done  out  1  one-cycle pulse when the last command is accepted
- rd_state_out  out  4  registered copy of the one-hot state

Behaviour:
- Depth window, as address width W per DIMMdepth_ctrl:
  - 1111:28, 1110:27, 1101:26, 1100:25, 1011:24, 1010:23, 1001:22, 1000:21
  - 0111:20, 0110:19, 0101:17, 0100:16, 0011:14, 0010:12, 0001:10, 0000:8
  - default: 20
- Burst window: B = W-3 bits; total bursts N = 2^B.
- trig_burst = addr_trig[26:2]; start_burst = (trig_burst - pre_bursts) mod 2^B. Only the low B bits are used, so pre_bursts >= N wraps silently.
- States (one-hot):
  - IDLE=0001: on rd_start=1, latch depth, addr_trig and pre_bursts, then go to LOAD.
  - LOAD=0010: compute the mask and start_burst; set burst_idx=start_burst and issued=0; go to ISSUE.
  - ISSUE=0100:
    - rd_cmd_valid may rise only when data_fifo_afull=0.
    - Once high, rd_cmd_valid and addr_rd_out stay stable until rd_cmd_rdy=1, regardless of afull.
    - On valid&rdy: burst_idx <= (burst_idx+1) & mask, issued <= issued+1.
    - If issued+1 == N, drop valid and go to DONE.
    - Otherwise re-assert valid next cycle if afull=0; back-to-back acceptance gives one command per cycle.
  - DONE=1000: rd_done=1 for exactly one cycle, then go to IDLE.
- Wrap: after burst_idx = N-1, the next address is 0. Bits above W are always 0.
- Latency: rd_start sampled at edge k puts the state in LOAD after k. The state is ISSUE and rd_cmd_valid=1 after edge k+2, provided afull=0.
- Reset (rst=0), including mid-operation: state=IDLE, rd_cmd_valid=0, addr_rd_out=0, rd_busy=0, rd_done=0, rd_state_out=0001 on the next edge; latched values are cleared. Any pending command is abandoned.
- Input conditions:
  - rd_start outside IDLE is ignored.
  - Depth or trigger changes after rd_start have no effect until the next start.
  - rd_cmd_rdy while valid=0 is ignored.
- rd_state_out lags the state by one cycle.

Test Plan:
- Depth 0000 (N=32), addr_trig=0x40, pre_bursts=8, rdy=1, afull=0 -> addresses 0x40,0x48..0xF8, then 0x00..0x38; exactly 32 commands; rd_done one cycle after the 32nd accept; valid first high 2 cycles after rd_start.
- Depth 0000, addr_trig=0x08, pre_bursts=5 -> first address 0xE8 (start burst 29); after 0xF8 the next address is 0x00; 32 commands total.
- Depth 1111, addr_trig=0x7FFFFFC, pre_bursts=0 -> first 0xFFFFFF8, second 0x0000000; bits [27:3] wrap correctly.
- Backpressure: rdy held low 5 cycles with valid high -> address stable and afull toggling has no effect. afull=1 before issue -> valid stays 0 until afull=0. Command count is still exactly N.
- rd_start pulse during ISSUE -> ignored, no restart. rst=0 mid-ISSUE -> valid=0 and state IDLE next edge, no rd_done; a new rd_start then runs a full sequence.
- pre_bursts=40 with depth 0000 -> treated as 8 (40 mod 32); same sequence as scenario 1.
